qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
- Responder (flash-side) end of the quad-SPI read link.
- Decodes csb/io transactions issued by the initiator-side QSPI interface and returns bytes from an internal byte-addressable memory.
- Used as the synthesizable flash stand-in for cache/QSPI integration benches and FPGA bring-up.
- Serial clock is the system clock: one io beat per clk rising edge while csb is low.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; power of two, minimum 16.
- DUMMY_CYCLES, 4, clk cycles between the last address nibble and the first data nibble; minimum 2.
- CMD_QREAD, 8'hEB, the only accepted command code.

Ports:
- clk  input  1  system/serial clock.
- rst  input  1  asynchronous, active-high reset.
- csb  input  1  chip select, active low.
- io  inout  4  quad data lines; driven only in DATA state, otherwise high-Z.
- load_en  input  1  memory preload write strobe.
- load_addr  input  $clog2(MEM_BYTES)  preload byte address.
- load_data  input  8  preload byte.
- busy  output  1  high while csb is low and state != IDLE.
- cmd_err  output  1  one-cycle pulse on receipt of an unsupported command.

Behaviour:
- Reset: state IDLE, io high-Z (oe=0), busy=0, cmd_err=0, address register 0. Memory contents are not reset.
- All io sampling and driving happens on the clk rising edge. csb is sampled synchronously.
- csb high on any edge: next state IDLE, oe=0. This aborts any phase with no error.
- IDLE -> CMD when csb is sampled low. Nibble counter is cleared. The same edge captures nibble 0.
- CMD: 2 beats, high nibble first. On the 2nd beat:
  - command == CMD_QREAD: go to ADDR.
  - otherwise: go to ERR and pulse cmd_err for 1 cycle.
- ADDR: 6 beats, 24-bit address, MSB nibble first. Only the low $clog2(MEM_BYTES) bits are kept; upper bits are ignored. Then go to DUMMY.
- DUMMY: DUMMY_CYCLES beats. io is not driven and input values are ignored, except as noted under the optional feature.
  - At the edge ending the last dummy beat: oe goes 1, the high nibble of mem[addr] is driven, and the state goes to DATA.
- DATA: each edge presents the next nibble. Order per byte: high nibble, then low nibble.
  - After a low nibble, addr increments modulo MEM_BYTES (wraps MEM_BYTES-1 -> 0).
  - Continues indefinitely until csb goes high.
  - Byte order is ascending address, so a 32-bit fetch at A returns mem[A], mem[A+1], mem[A+2], mem[A+3] in that order.
- ERR: io high-Z and inputs ignored until csb goes high.
- Latency: the initiator samples the first data nibble on edge 2+6+DUMMY_CYCLES+1 counted from the first csb-low edge (edge 13 with defaults).
- busy = (state != IDLE).
- Preload:
  - load_en writes mem[load_addr] = load_data on the edge.
  - Allowed at any time. A write to the byte currently being read takes effect for the low nibble if the high nibble has already been sent. No arbitration is needed because the memory has one write port and one read port.
- csb high for a single cycle between transactions is sufficient; back-to-back transactions are supported.
- Reset mid-transaction: immediate high-Z and IDLE. csb low at reset release starts a new CMD only after csb has been seen high once (armed flag).

Optional Feature:
- Macro: QSPI_RESP_CONT_READ_EN.
- Enabled:
  - The first 2 DUMMY beats are captured as mode byte M (high nibble first).
  - If M[7:4] == 4'hA, a cont flag is set. The next transaction's IDLE -> ADDR transition skips CMD; the first csb-low edge captures address nibble 0.
  - Any other M clears cont.
  - cont is cleared by reset and by ERR.
- Disabled: mode beats are ignored, cont logic is absent, and every transaction starts with CMD.

Test Plan:
1. Preload mem[0x10..0x13] = 11,22,33,44. Issue EB, addr 0x000010, 4 dummy beats, read 8 nibbles -> io sequence 1,1,2,2,3,3,4,4; the first data nibble is valid at edge 13.
2. Read at addr 0x0003FF (MEM_BYTES=1024) with mem[0x3FF]=AB, mem[0]=CD -> nibbles A,B,C,D (wrap).
3. Command 0x03 -> cmd_err pulses exactly 1 cycle after the 2nd beat; io stays high-Z until csb goes high; the next EB transaction works normally.
4. Raise csb after 3 address nibbles, then start a full EB read at 0x10 -> data is correct, with no residue from the aborted address.
5. Assert rst during DATA -> io high-Z and busy=0 in the same cycle; holding csb low after release produces no response until a csb high/low cycle.
6. With QSPI_RESP_CONT_READ_EN: first transaction has mode byte 0xA5; second transaction sends only addr 0x000012 plus dummy beats -> returns mem[0x12]. A mode byte of 0x00 in the second transaction makes the third transaction require the command again.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// Quad-SPI flash-side responder: EB quad read from an internal byte memory.
// Define QSPI_RESP_CONT_READ_EN to enable continuous-read (mode byte 0xAx).
module qspi_flash_responder #(
    parameter int         MEM_BYTES    = 1024,
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] CMD_QREAD    = 8'hEB
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         csb,
    inout  wire  [3:0]                   io,
    input  logic                         load_en,
    input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
    input  logic [7:0]                   load_data,
    output logic                         busy,
    output logic                         cmd_err
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = $clog2(DUMMY_CYCLES + 8);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ERR
    } state_t;

    logic [7:0]    mem [MEM_BYTES];
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [AW-1:0] addr, addr_d;
    logic [3:0]    nib;
    logic          lo, lo_d;
    logic          armed;
    logic          err_d;
    logic [7:0]    rd_byte;
`ifdef QSPI_RESP_CONT_READ_EN
    logic          cont, cont_d;
`endif

    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    assign rd_byte = mem[addr];
    assign busy    = (state != IDLE);
    assign io      = (state == DATA) ? (lo ? rd_byte[3:0] : rd_byte[7:4])
                                     : 4'bz;

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        addr_d  = addr;
        lo_d    = lo;
        err_d   = 1'b0;
`ifdef QSPI_RESP_CONT_READ_EN
        cont_d  = cont;
`endif
        if (csb) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    // Low csb right after reset is ignored until csb was seen high.
                    if (armed) begin
                        cnt_d   = CW'(1);
                        state_d = CMD;
`ifdef QSPI_RESP_CONT_READ_EN
                        if (cont) begin
                            state_d = ADDR;
                            addr_d  = AW'({addr, io});
                        end
`endif
                    end
                end
                CMD: begin
                    cnt_d = cnt + 1'b1;
                    if (cnt == CW'(1)) begin
                        cnt_d = '0;
                        if ({nib, io} == CMD_QREAD) begin
                            state_d = ADDR;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
`ifdef QSPI_RESP_CONT_READ_EN
                            cont_d  = 1'b0;
`endif
                        end
                    end
                end
                ADDR: begin
                    // Shifting keeps only the low AW bits of the 24-bit address.
                    addr_d = AW'({addr, io});
                    cnt_d  = cnt + 1'b1;
                    if (cnt == CW'(5)) begin
                        cnt_d   = '0;
                        state_d = DUMMY;
                    end
                end
                DUMMY: begin
                    cnt_d = cnt + 1'b1;
`ifdef QSPI_RESP_CONT_READ_EN
                    if (cnt == CW'(1)) cont_d = (nib == 4'hA);
`endif
                    if (cnt == CW'(DUMMY_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = DATA;
                        lo_d    = 1'b0;
                    end
                end
                DATA: begin
                    lo_d = !lo;
                    if (lo) addr_d = addr + 1'b1;
                end
                ERR: begin
                    state_d = ERR;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            lo      <= 1'b0;
            nib     <= '0;
            armed   <= 1'b0;
            cmd_err <= 1'b0;
`ifdef QSPI_RESP_CONT_READ_EN
            cont    <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr    <= addr_d;
            lo      <= lo_d;
            nib     <= io;
            cmd_err <= err_d;
            if (csb) armed <= 1'b1;
`ifdef QSPI_RESP_CONT_READ_EN
            cont    <= cont_d;
`endif
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Scoreboard bench for qspi_flash_responder: random reads against a byte-array model.
// Covers both builds of QSPI_RESP_CONT_READ_EN.
module tb_qspi_flash_responder;

    localparam int MEM   = 1024;
    localparam int DUMMY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       csb = 1'b1;
    logic       load_en = 1'b0;
    logic [9:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       tb_oe = 1'b0;
    logic [3:0] tb_io = '0;
    wire  [3:0] io;
    logic       busy;
    logic       cmd_err;

    assign io = tb_oe ? tb_io : 4'bz;

    always #5 clk = ~clk;

    qspi_flash_responder #(
        .MEM_BYTES   (MEM),
        .DUMMY_CYCLES(DUMMY),
        .CMD_QREAD   (8'hEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .csb      (csb),
        .io       (io),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    logic [7:0] ref_mem [MEM];
    bit         ref_cont = 1'b0;
    logic [3:0] exp_q [$];
    logic [3:0] hdr_q [$];
    bit         rd_win = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] mon_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: each driven data beat is compared with the next queued nibble.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rd_win) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got io=%0h, required nothing pending", io);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data_nibble", io, mon_e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    task automatic load(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic build_hdr(input logic [23:0] a);
        logic [7:0] c;
        c = 8'hEB;
        hdr_q.delete();
        if (!ref_cont) begin
            hdr_q.push_back(c[7:4]);
            hdr_q.push_back(c[3:0]);
        end
        for (int i = 5; i >= 0; i--) hdr_q.push_back(a[i*4 +: 4]);
    endtask

    task automatic send(input logic [3:0] n);
        @(negedge clk);
        csb   = 1'b0;
        tb_oe = 1'b1;
        tb_io = n;
    endtask

    task automatic push_exp(input logic [23:0] a, input int nnib);
        int         ad;
        logic [7:0] b;
        for (int k = 0; k < nnib; k++) begin
            ad = (int'(a) + k / 2) % MEM;
            b  = ref_mem[ad];
            exp_q.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
        end
    endtask

    task automatic start_read(input logic [23:0] a, input logic [7:0] mode);
        build_hdr(a);
        foreach (hdr_q[i]) send(hdr_q[i]);
        for (int d = 0; d < DUMMY - 1; d++)
            send(d == 0 ? mode[7:4] : d == 1 ? mode[3:0] : 4'($urandom));
        @(negedge clk);
        tb_oe = 1'b0;
`ifdef QSPI_RESP_CONT_READ_EN
        ref_cont = (mode[7:4] == 4'hA);
`endif
    endtask

    task automatic read_data(input int n);
        repeat (n) begin
            @(negedge clk);
            rd_win = 1'b1;
        end
    endtask

    task automatic end_txn();
        @(negedge clk);
        rd_win = 1'b0;
        csb    = 1'b1;
        tb_oe  = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a, input int nbytes,
                           input logic [7:0] mode);
        push_exp(a, 2 * nbytes);
        start_read(a, mode);
        read_data(2 * nbytes);
        end_txn();
    endtask

    task automatic do_abort(input logic [23:0] a, input int k);
        build_hdr(a);
        for (int i = 0; i < k && i < hdr_q.size(); i++) send(hdr_q[i]);
        @(negedge clk);
        csb   = 1'b1;
        tb_oe = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 1);
    endtask

    task automatic do_err();
        logic [3:0] r;
        send(4'h0);
        @(negedge clk);
        tb_io = 4'h3;
        #1;
        chk("cmd_err_early", 32'(cmd_err), 0);
        for (int i = 0; i < 4; i++) begin
            r = 4'($urandom);
            @(negedge clk);
            tb_io = r;
            #1;
            chk("err_hiz", 32'(io), 32'(r));
            chk("err_busy", 32'(busy), 1);
            chk("cmd_err_pulse", 32'(cmd_err), (i == 0) ? 1 : 0);
        end
        @(negedge clk);
        csb   = 1'b1;
        tb_oe = 1'b0;
        ref_cont = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [7:0]  old_b, new_b;
        logic [23:0] ra;
        int          sel;

        tb_oe = 1'b1;
        tb_io = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_err", 32'(cmd_err), 0);
        chk("rst_hiz", 32'(io), 0);
        tb_oe = 1'b0;

        for (int i = 0; i < MEM; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 10'(i);
            load_data = 8'($urandom);
            ref_mem[i] = load_data;
        end
        @(negedge clk);
        load_en = 1'b0;
        rst     = 1'b0;

        load(10'h010, 8'h11);
        load(10'h011, 8'h22);
        load(10'h012, 8'h33);
        load(10'h013, 8'h44);
        do_read(24'h000010, 4, 8'h00);

        load(10'h3FF, 8'hAB);
        load(10'h000, 8'hCD);
        do_read(24'h0003FF, 2, 8'h00);
        do_read(24'hC5_03FF, 2, 8'h00);

        do_err();
        do_read(24'h000010, 4, 8'h00);

        do_abort(24'h0002A5, 5);
        do_read(24'h000010, 4, 8'h00);

        push_exp(24'h000010, 3);
        start_read(24'h000010, 8'h00);
        read_data(3);
        @(negedge clk);
        rd_win = 1'b0;
        tb_oe  = 1'b1;
        tb_io  = 4'h0;
        rst    = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_hiz", 32'(io), 0);
        ref_cont = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        build_hdr(24'h000010);
        foreach (hdr_q[i]) begin
            @(negedge clk);
            tb_io = hdr_q[i];
            #1;
            chk("armed_busy", 32'(busy), 0);
        end
        repeat (DUMMY + 4) begin
            @(negedge clk);
            tb_io = 4'h0;
            #1;
            chk("armed_hiz", 32'(io), 0);
        end
        @(negedge clk);
        csb   = 1'b1;
        tb_oe = 1'b0;
        do_read(24'h000010, 4, 8'h00);

        old_b = ref_mem[32];
        new_b = 8'($urandom);
        if (new_b[3:0] == old_b[3:0]) new_b[3:0] = ~old_b[3:0];
        exp_q.push_back(old_b[7:4]);
        exp_q.push_back(new_b[3:0]);
        push_exp(24'h000021, 2);
        start_read(24'h000020, 8'h00);
        @(negedge clk);
        rd_win    = 1'b1;
        load_en   = 1'b1;
        load_addr = 10'h020;
        load_data = new_b;
        ref_mem[32] = new_b;
        @(negedge clk);
        load_en = 1'b0;
        read_data(2);
        end_txn();

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            ra  = 24'($urandom);
            if (sel < 2) begin
                repeat ($urandom_range(1, 3)) load(10'($urandom), 8'($urandom));
            end else if (sel == 2) begin
                do_abort(ra, $urandom_range(1, ref_cont ? 6 : 8));
            end else begin
                old_b = 8'($urandom);
                if ($urandom_range(0, 1) == 1) old_b[7:4] = 4'hA;
                do_read(ra, $urandom_range(1, 5), old_b);
            end
        end

`ifdef QSPI_RESP_CONT_READ_EN
        do_read(24'h000030, 1, 8'h00);
        do_read(24'h000010, 4, 8'hA5);
        do_read(24'h000012, 1, 8'h00);
        do_read(24'h000011, 2, 8'h00);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
